// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants and payload types.
package mips_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned ADDR_W  = 32;

  // sll $0,$0,0 doubles as the pipeline bubble
  localparam logic [INSTR_W-1:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [ADDR_W-1:0]  DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [ADDR_W-1:0]  PC_STEP          = 32'd4;

  // One fetched instruction together with the address it came from
  typedef struct packed {
    logic               valid;
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry skid register holding an instruction response that arrived
// while the pipeline was stalled.
//   clk, rst_n        : clock, async active-low reset
//   capture           : load instr/pc and mark the entry valid
//   clear             : invalidate the entry (wins over capture)
//   in_instr, in_pc   : response to capture
//   valid, instr, pc  : held entry
module fetch_skid_buffer
  import mips_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               capture,
  input  logic               clear,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [ADDR_W-1:0]  in_pc,
  output logic               valid,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  pc
);

  // Capture/hold/clear register; clear has priority
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      instr <= NOP_INSTR;
      pc    <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (capture) begin
      valid <= 1'b1;
      instr <= in_instr;
      pc    <= in_pc;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC register, synchronous imem requests,
// stall skid capture, branch/jump redirect with bubble insertion, IF/ID.
//   clk, rst_n                  : clock, async active-low reset
//   stall                       : hold PC and IF/ID this cycle
//   branch_taken, branch_target : taken branch resolved in ID
//   jump, jump_target           : j/jal in ID (wins over branch)
//   imem_req, imem_addr         : read request / address this cycle
//   imem_rdata                  : data for last cycle's request
//   ifid_instr/pc4/valid        : IF/ID pipeline register
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  input  logic               jump,
  input  logic [ADDR_W-1:0]  jump_target,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic [ADDR_W-1:0]  ifid_pc4,
  output logic               ifid_valid
);

  logic [ADDR_W-1:0]  pc_q;
  logic               f2_valid;
  logic [ADDR_W-1:0]  f2_pc;
  logic               skid_valid;
  logic [INSTR_W-1:0] skid_instr;
  logic [ADDR_W-1:0]  skid_pc;
  logic               redirect;
  logic [ADDR_W-1:0]  target;
  fetch_entry_t       src;

  // Stall masks the redirect: the hazard unit stalls while operands are unresolved
  assign redirect  = (branch_taken | jump) & ~stall;
  assign target    = jump ? jump_target : branch_target;
  assign imem_req  = rst_n & ~stall;
  assign imem_addr = pc_q;

  // IF/ID source: a held skid entry is older than the response on the bus
  always_comb begin
    src = '{valid: 1'b0, instr: NOP_INSTR, pc: f2_pc};
    if (skid_valid) begin
      src = '{valid: 1'b1, instr: skid_instr, pc: skid_pc};
    end else if (f2_valid) begin
      src = '{valid: 1'b1, instr: imem_rdata, pc: f2_pc};
    end
  end

  // PC and in-flight request tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= RESET_PC;
      f2_valid <= 1'b0;
      f2_pc    <= '0;
    end else if (stall) begin
      f2_valid <= 1'b0;
    end else if (redirect) begin
      pc_q     <= target;
      f2_valid <= 1'b0;
    end else begin
      pc_q     <= pc_q + PC_STEP;
      f2_valid <= 1'b1;
      f2_pc    <= pc_q;
    end
  end

  // IF/ID register; bubbles keep the previous pc4
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifid_instr <= NOP_INSTR;
      ifid_pc4   <= '0;
      ifid_valid <= 1'b0;
    end else if (!stall) begin
      if (redirect || !src.valid) begin
        ifid_instr <= NOP_INSTR;
        ifid_valid <= 1'b0;
      end else begin
        ifid_instr <= src.instr;
        ifid_pc4   <= src.pc + PC_STEP;
        ifid_valid <= 1'b1;
      end
    end
  end

  // Any non-stalled cycle either consumes or discards the skid entry
  fetch_skid_buffer u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .capture  (stall & f2_valid),
    .clear    (~stall),
    .in_instr (imem_rdata),
    .in_pc    (f2_pc),
    .valid    (skid_valid),
    .instr    (skid_instr),
    .pc       (skid_pc)
  );

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, branch_taken, jump;
  logic [31:0] branch_target, jump_target;
  logic        imem_req, imem_req_w;
  logic [31:0] imem_addr, imem_addr_w, imem_rdata, imem_rdata_w;
  logic [31:0] ifid_instr, ifid_pc4, ifid_instr_w, ifid_pc4_w;
  logic        ifid_valid, ifid_valid_w;

  int checks = 0;
  int errors = 0;

  // Reference model: transaction level, a queue of fetched-but-undelivered addresses
  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_valid;
  logic [31:0] m_q[$];

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .ifid_instr(ifid_instr), .ifid_pc4(ifid_pc4), .ifid_valid(ifid_valid)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_w (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target),
    .imem_req(imem_req_w), .imem_addr(imem_addr_w), .imem_rdata(imem_rdata_w),
    .ifid_instr(ifid_instr_w), .ifid_pc4(ifid_pc4_w), .ifid_valid(ifid_valid_w)
  );

  // Synchronous instruction memories: word at addr holds addr>>2; junk when idle
  always @(posedge clk) begin
    imem_rdata   <= imem_req   ? (imem_addr   >> 2) : 32'($urandom);
    imem_rdata_w <= imem_req_w ? (imem_addr_w >> 2) : 32'($urandom);
  end

  task automatic model_reset();
    m_pc = 32'h0; m_q.delete(); m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
  endtask

  task automatic model_step();
    logic [31:0] a;
    if (stall) begin
      // everything holds, in-flight fetch is kept
    end else if (branch_taken || jump) begin
      m_q.delete();
      m_valid = 1'b0;
      m_instr = 32'h0;
      m_pc    = jump ? jump_target : branch_target;
    end else begin
      if (m_q.size() > 0) begin
        a = m_q.pop_front();
        m_instr = a >> 2; m_pc4 = a + 32'd4; m_valid = 1'b1;
      end else begin
        m_instr = 32'h0; m_valid = 1'b0;
      end
      m_q.push_back(m_pc);
      m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic set_in(input logic st, input logic br, input logic [31:0] bt,
                        input logic j, input logic [31:0] jt);
    stall = st; branch_taken = br; branch_target = bt; jump = j; jump_target = jt;
  endtask

  // Advance one clock: model and DUT see the same inputs; returns at negedge
  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set_in(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_in(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    model_reset();
    @(negedge clk);
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", imem_req); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h exp 00000000", imem_addr); end
    checks++; if ({ifid_valid, ifid_instr, ifid_pc4} !== 65'h0) begin errors++; $display("FAIL reset_ifid got v%b %h %h exp all 0", ifid_valid, ifid_instr, ifid_pc4); end
    checks++; if (imem_addr_w !== 32'hFFFF_FFF8) begin errors++; $display("FAIL reset_addr_w got %h exp fffffff8", imem_addr_w); end
    checks++; if ({ifid_valid_w, ifid_instr_w, ifid_pc4_w} !== 65'h0) begin errors++; $display("FAIL reset_ifid_w got v%b %h %h exp all 0", ifid_valid_w, ifid_instr_w, ifid_pc4_w); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL release_req got %b exp 1", imem_req); end
  endtask

  // Runs straight after test_reset; checks the RESET_PC=FFFF_FFF8 instance wraps
  task automatic test_wrap();
    logic [31:0] exp_a, prev_a;
    prev_a = 32'h0;
    for (int i = 0; i < 4; i++) begin
      exp_a = 32'hFFFF_FFF8 + 32'(4 * i);
      #1;
      checks++; if (imem_addr_w !== exp_a) begin errors++; $display("FAIL wrap_addr cyc %0d got %h exp %h", i, imem_addr_w, exp_a); end
      tick();
      if (i >= 1) begin
        checks++;
        if (ifid_valid_w !== 1'b1 || ifid_instr_w !== (prev_a >> 2) || ifid_pc4_w !== prev_a + 32'd4) begin
          errors++;
          $display("FAIL wrap_ifid cyc %0d got v%b %h %h exp v1 %h %h", i, ifid_valid_w, ifid_instr_w, ifid_pc4_w, prev_a >> 2, prev_a + 32'd4);
        end
      end
      prev_a = exp_a;
    end
  endtask

  task automatic test_sequential();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      #1;
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'(4 * i)) begin errors++; $display("FAIL seq_req cyc %0d got %b %h exp 1 %h", i, imem_req, imem_addr, 32'(4 * i)); end
      tick();
      if (i == 0) begin
        checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL seq_first_bubble got v%b exp v0", ifid_valid); end
      end else begin
        checks++;
        if (ifid_valid !== 1'b1 || ifid_instr !== 32'(i - 1) || ifid_pc4 !== 32'(4 * i)) begin
          errors++;
          $display("FAIL seq_ifid cyc %0d got v%b %h %h exp v1 %h %h", i, ifid_valid, ifid_instr, ifid_pc4, 32'(i - 1), 32'(4 * i));
        end
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    repeat (3) tick();
    checks++; if (ifid_pc4 !== 32'd8) begin errors++; $display("FAIL stall_setup pc4 got %h exp 00000008", ifid_pc4); end
    for (int k = 0; k < 3; k++) begin
      set_in(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      #1;
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL stall_req cyc %0d got %b exp 0", k, imem_req); end
      tick();
      checks++;
      if (ifid_valid !== 1'b1 || ifid_instr !== 32'd1 || ifid_pc4 !== 32'd8) begin
        errors++;
        $display("FAIL stall_hold cyc %0d got v%b %h %h exp v1 00000001 00000008", k, ifid_valid, ifid_instr, ifid_pc4);
      end
    end
    set_in(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (ifid_valid !== 1'b1 || ifid_instr !== 32'(2 + k) || ifid_pc4 !== 32'(12 + 4 * k)) begin
        errors++;
        $display("FAIL stall_resume cyc %0d got v%b %h %h exp v1 %h %h", k, ifid_valid, ifid_instr, ifid_pc4, 32'(2 + k), 32'(12 + 4 * k));
      end
    end
  endtask

  task automatic test_branch();
    int n;
    do_reset();
    n = 0;
    while (m_pc != 32'h20 && n < 20) begin tick(); n++; end
    #1;
    checks++; if (imem_addr !== 32'h20) begin errors++; $display("FAIL br_setup addr got %h exp 00000020", imem_addr); end
    set_in(1'b0, 1'b1, 32'h100, 1'b0, 32'h0);
    tick();
    set_in(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    checks++; if (imem_addr !== 32'h100) begin errors++; $display("FAIL br_addr got %h exp 00000100", imem_addr); end
    for (int k = 0; k < 2; k++) begin
      checks++; if (ifid_valid !== 1'b0 || ifid_instr !== 32'h0) begin errors++; $display("FAIL br_bubble %0d got v%b %h exp v0 00000000", k, ifid_valid, ifid_instr); end
      tick();
    end
    checks++;
    if (ifid_valid !== 1'b1 || ifid_instr !== 32'h40 || ifid_pc4 !== 32'h104) begin
      errors++;
      $display("FAIL br_target got v%b %h %h exp v1 00000040 00000104", ifid_valid, ifid_instr, ifid_pc4);
    end
  endtask

  task automatic test_stall_jump();
    logic [31:0] hold_pc;
    do_reset();
    repeat (4) tick();
    hold_pc = m_pc;
    repeat (2) begin
      set_in(1'b1, 1'b0, 32'h0, 1'b1, 32'h200);
      tick();
      checks++; if (imem_addr !== hold_pc) begin errors++; $display("FAIL sj_no_redirect got %h exp %h", imem_addr, hold_pc); end
    end
    set_in(1'b0, 1'b0, 32'h0, 1'b1, 32'h200);
    tick();
    set_in(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    checks++; if (imem_addr !== 32'h200 || ifid_valid !== 1'b0) begin errors++; $display("FAIL sj_taken got %h v%b exp 00000200 v0", imem_addr, ifid_valid); end
    tick();
    checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL sj_bubble2 got v%b exp v0", ifid_valid); end
    tick();
    checks++;
    if (ifid_valid !== 1'b1 || ifid_instr !== 32'h80 || ifid_pc4 !== 32'h204) begin
      errors++;
      $display("FAIL sj_target got v%b %h %h exp v1 00000080 00000204", ifid_valid, ifid_instr, ifid_pc4);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    repeat (4) tick();
    set_in(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    repeat (2) tick();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b0 || imem_addr !== 32'h0 || {ifid_valid, ifid_instr, ifid_pc4} !== 65'h0) begin
      errors++;
      $display("FAIL midreset got req%b %h v%b %h %h exp all 0", imem_req, imem_addr, ifid_valid, ifid_instr, ifid_pc4);
    end
    model_reset();
    set_in(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL midreset_no_replay got v%b %h exp v0", ifid_valid, ifid_instr); end
    tick();
    checks++;
    if (ifid_valid !== 1'b1 || ifid_instr !== 32'h0 || ifid_pc4 !== 32'h4) begin
      errors++;
      $display("FAIL midreset_restart got v%b %h %h exp v1 00000000 00000004", ifid_valid, ifid_instr, ifid_pc4);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      set_in($urandom_range(0, 9) < 3, $urandom_range(0, 11) == 0, $urandom & 32'h0000_0FFC,
             $urandom_range(0, 13) == 0, $urandom & 32'h0000_0FFC);
      #1;
      checks++;
      if (imem_req !== ~stall || imem_addr !== m_pc) begin
        errors++;
        $display("FAIL rnd_req cyc %0d got %b %h exp %b %h", c, imem_req, imem_addr, ~stall, m_pc);
      end
      tick();
      checks++;
      if (ifid_valid !== m_valid || ifid_instr !== m_instr || (m_valid && ifid_pc4 !== m_pc4)) begin
        errors++;
        $display("FAIL rnd_ifid cyc %0d got v%b %h %h exp v%b %h %h", c, ifid_valid, ifid_instr, ifid_pc4, m_valid, m_instr, m_pc4);
      end
    end
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_sequential();
    test_stall();
    test_branch();
    test_stall_jump();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch front end of the five-stage MIPS pipeline. It owns the PC register, issues reads to a synchronous (1-cycle-latency) instruction memory, and drives the IF/ID pipeline register. It is the consumer of the hazard-detection unit's `stall` output and of the ID-stage branch/jump resolution. On a stall it holds the PC and IF/ID and captures the in-flight memory response in a one-entry skid buffer. On a redirect it squashes wrong-path fetches and inserts bubbles.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `stall`  in  1  from hazard detection; hold PC and IF/ID this cycle.
- `branch_taken`  in  1  beq/bne resolved taken in ID.
- `branch_target`  in  32  branch destination.
- `jump`  in  1  j/jal in ID.
- `jump_target`  in  32  jump destination.
- `imem_req`  out  1  read request this cycle.
- `imem_addr`  out  32  read address (byte address, word aligned).
- `imem_rdata`  in  32  instruction for the address requested in the previous cycle.
- `ifid_instr`  out  32  instruction presented to ID.
- `ifid_pc4`  out  32  PC+4 of `ifid_instr`.
- `ifid_valid`  out  1  `ifid_instr` is a real instruction (0 = bubble).

## Operation
- State:
  - `pc_q`: next address to request.
  - `f2_valid`/`f2_pc`: a request issued last cycle whose data is on `imem_rdata` now.
  - Skid entry: `skid_valid`/`skid_instr`/`skid_pc`.
  - IF/ID registers.
- `imem_addr = pc_q` always. `imem_req = rst_n & ~stall`.
- Redirect = `(branch_taken | jump) & ~stall`. Target is `jump_target` if `jump`, else `branch_target`. If both are set, jump wins.
- Stall has absolute priority: the redirect inputs are ignored while `stall=1`, because the hazard unit stalls precisely when branch operands are not ready.
- Normal cycle (no stall, no redirect):
  - `pc_q <= pc_q+4`; `f2_valid <= 1`; `f2_pc <= pc_q`.
  - IF/ID source is the skid entry if `skid_valid`, else `imem_rdata`/`f2_pc` when `f2_valid`, else a bubble.
  - Load IF/ID from that source, with `ifid_pc4 = src_pc+4`. Clear the skid.
- Stall cycle:
  - PC and IF/ID hold. `f2_valid <= 0`.
  - If `f2_valid`, capture `imem_rdata`/`f2_pc` into the skid (`skid_valid <= 1`). Otherwise the skid holds.
  - The skid never overflows: at most one response is in flight when a stall begins, and no request is issued while stalled.
- Redirect cycle:
  - `pc_q <= target`; `f2_valid <= 0`; `skid_valid <= 0`.
  - `ifid_valid <= 0` and `ifid_instr <= NOP`, with `ifid_pc4` holding. The wrong-path instruction is discarded.
- Bubble encoding: `ifid_instr = 32'h0000_0000` (sll $0,$0,0), `ifid_valid = 0`.
- Arithmetic: all PC adds are 32-bit, modulo 2^32. 32'hFFFF_FFFC + 4 wraps to 0. Low two bits of targets are passed through unchecked.

## Timing
- Reset (async assert, sync release): `pc_q = RESET_PC`, `f2_valid = 0`, `skid_valid = 0`, `ifid_instr = 0`, `ifid_pc4 = 0`, `ifid_valid = 0`, `imem_req = 0`.
- First cycle after release: request `RESET_PC`. The first instruction is in IF/ID (`ifid_valid = 1`) two edges after release.
- Steady state throughput: 1 instruction/cycle. Fetch-to-ID latency: 2 cycles.
- Redirect asserted in cycle N: `imem_addr = target` in N+1, `ifid_valid = 0` in N+1 and N+2, target instruction in IF/ID in N+3 (2-bubble penalty).
- Stall for K cycles: IF/ID is unchanged for K cycles. In the first cycle after release, IF/ID loads the skid entry. No instruction is lost or duplicated.
- Stall and redirect in the same cycle: stall behaviour only. A redirect in the release cycle is honoured and also clears the skid.
- Reset asserted mid-operation: all state returns to reset values immediately. Any in-flight response is discarded.

## Structure
- Shared package `mips_pkg`: `NOP_INSTR` (32'h0), `DEFAULT_RESET_PC`, `INSTR_W = 32`.
- One sub-module, `fetch_skid_buffer`: one-entry capture/hold/clear register with fields valid/instr/pc, plus a clear-priority input. PC, redirect mux and IF/ID stay in `fetch_unit`.

## Test plan
- Reset release, memory returns `addr>>2`, no stall: `ifid_instr` = 0,1,2,3… from edge 2 onward, `ifid_pc4` = 4,8,12…
- Stall for 3 cycles while `ifid_pc4 = 8`: IF/ID holds 8 for 3 cycles, `imem_req = 0`, then `ifid_pc4` = 12,16,… with no gap or repeat.
- `branch_taken` with target 32'h100 at `pc_q = 32'h20`: `imem_addr = 32'h100` next cycle, two bubbles (`ifid_valid = 0`, `instr = 0`), then `ifid_pc4 = 32'h104`.
- `stall = 1`, `jump = 1` in the same cycle: PC is not redirected. Jump repeated in the release cycle is taken and the skid is discarded.
- `RESET_PC = 32'hFFFF_FFF8`: fetches FFFF_FFF8, FFFF_FFFC, 0000_0000 (wrap).
- `rst_n` pulsed low during a stall with the skid full: all outputs return to reset values, and fetch restarts at `RESET_PC` with no skid replay.
